hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage CPU. It sits beside the IF/ID and ID/EX registers.
- Detects load-use hazards and holds the pipeline for a configurable memory latency.
- Interlocks consumers of a multi-cycle multiply/divide unit (MDU) for as long as the MDU is busy.
- Generates flushes on a taken branch.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_unit.sv | 114 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Load-use / MDU interlock and branch flush control for the 5-stage pipeline.
// Also keeps a saturating count of stall cycles.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rs,
    input  logic              if_id_uses_rt,
    input  logic              id_ex_mdu_start,
    input  logic              if_id_uses_mdu,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              control_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int LCW = $clog2(LOAD_LAT + 1);
    localparam int MCW = $clog2(MDU_LAT + 1);
    localparam logic [LCW-1:0] LD_INIT  = LCW'(LOAD_LAT - 1);
    localparam logic [MCW-1:0] MDU_INIT = MCW'(MDU_LAT);
    localparam bit MULTI = (LOAD_LAT > 1);

    typedef enum logic {IDLE, LD_WAIT} state_t;

    state_t           state, state_nx;
    logic [LCW-1:0]   ld_cnt, ld_cnt_nx;
    logic [MCW-1:0]   mdu_cnt;
    logic             load_hit, mdu_hit, stall;

    assign load_hit = id_ex_mem_read && (id_ex_rt != '0) &&
                      ((if_id_uses_rs && (if_id_rs == id_ex_rt)) ||
                       (if_id_uses_rt && (if_id_rt == id_ex_rt)));
    assign mdu_busy = (mdu_cnt != '0);
    assign mdu_hit  = mdu_busy && if_id_uses_mdu;
    assign stall    = (state == LD_WAIT) ||
                      ((state == IDLE) && load_hit) || mdu_hit;

    // Outputs are forced to their reset values while rst_n is low.
    assign pc_write      = !rst_n || branch_taken || !stall;
    assign if_id_write   = !rst_n || branch_taken || !stall;
    assign control_stall = rst_n && !branch_taken && stall;
    assign if_id_flush   = rst_n && branch_taken;
    assign id_ex_flush   = rst_n && branch_taken;

    always_comb begin
        state_nx  = state;
        ld_cnt_nx = ld_cnt;
        unique case (state)
            IDLE: begin
                if (load_hit && MULTI) begin
                    state_nx  = LD_WAIT;
                    ld_cnt_nx = LD_INIT;
                end
            end
            LD_WAIT: begin
                ld_cnt_nx = ld_cnt - 1'b1;
                if (ld_cnt <= LCW'(1)) begin
                    state_nx  = IDLE;
                    ld_cnt_nx = '0;
                end
            end
            default: begin
                state_nx  = IDLE;
                ld_cnt_nx = '0;
            end
        endcase
        // A taken branch squashes the waiting consumer.
        if (branch_taken) begin
            state_nx  = IDLE;
            ld_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ld_cnt <= '0;
        end else begin
            state  <= state_nx;
            ld_cnt <= ld_cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_cnt <= '0;
        end else if (id_ex_mdu_start) begin
            mdu_cnt <= MDU_INIT;
        end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (control_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three parameterisations share one stimulus,
// checked every cycle against a stall-budget model plus literal spot checks.
module tb_hazard_ctrl_unit;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       mem_read, uses_rs, uses_rt, mdu_start, uses_mdu, branch;
    logic [4:0] ex_rt, rs, rt;

    logic [2:0]  pc_v, ifid_v, ctrl_v, iff_v, exf_v, busy_v;
    logic [15:0] sc0, sc1;
    logic [1:0]  sc2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .MDU_LAT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
        .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rs(uses_rs), .if_id_uses_rt(uses_rt),
        .id_ex_mdu_start(mdu_start), .if_id_uses_mdu(uses_mdu), .branch_taken(branch),
        .pc_write(pc_v[0]), .if_id_write(ifid_v[0]), .control_stall(ctrl_v[0]),
        .if_id_flush(iff_v[0]), .id_ex_flush(exf_v[0]), .mdu_busy(busy_v[0]),
        .stall_cnt(sc0));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .MDU_LAT(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
        .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rs(uses_rs), .if_id_uses_rt(uses_rt),
        .id_ex_mdu_start(mdu_start), .if_id_uses_mdu(uses_mdu), .branch_taken(branch),
        .pc_write(pc_v[1]), .if_id_write(ifid_v[1]), .control_stall(ctrl_v[1]),
        .if_id_flush(iff_v[1]), .id_ex_flush(exf_v[1]), .mdu_busy(busy_v[1]),
        .stall_cnt(sc1));

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .MDU_LAT(4), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
        .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rs(uses_rs), .if_id_uses_rt(uses_rt),
        .id_ex_mdu_start(mdu_start), .if_id_uses_mdu(uses_mdu), .branch_taken(branch),
        .pc_write(pc_v[2]), .if_id_write(ifid_v[2]), .control_stall(ctrl_v[2]),
        .if_id_flush(iff_v[2]), .id_ex_flush(exf_v[2]), .mdu_busy(busy_v[2]),
        .stall_cnt(sc2));

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    function automatic int get_cnt(input int i);
        if (i == 0) return int'(sc0);
        if (i == 1) return int'(sc1);
        return int'(sc2);
    endfunction

    // Model: each instance owes a number of extra load-stall cycles;
    // the MDU owes a number of busy cycles.
    localparam int LAT[3]  = '{1, 3, 1};
    localparam int CMAX[3] = '{65535, 65535, 3};
    int ld_rem[3], cnt[3], mdu_rem;
    int ld_rem_nx[3], cnt_nx[3], mdu_rem_nx;

    always @(negedge clk) begin
        bit lh, st, e_ctrl;
        lh = mem_read && (ex_rt != 0) &&
             ((uses_rs && rs == ex_rt) || (uses_rt && rt == ex_rt));
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk("rst_pc", pc_v[i], 1);
                chk("rst_ifid", ifid_v[i], 1);
                chk("rst_ctrl", ctrl_v[i], 0);
                chk("rst_iff", iff_v[i], 0);
                chk("rst_exf", exf_v[i], 0);
                chk("rst_busy", busy_v[i], 0);
                chk("rst_cnt", get_cnt(i), 0);
            end else begin
                st = (ld_rem[i] > 0) || lh || (mdu_rem > 0 && uses_mdu);
                e_ctrl = st && !branch;
                chk("m_pc", pc_v[i], !e_ctrl);
                chk("m_ifid", ifid_v[i], !e_ctrl);
                chk("m_ctrl", ctrl_v[i], e_ctrl);
                chk("m_iff", iff_v[i], branch);
                chk("m_exf", exf_v[i], branch);
                chk("m_busy", busy_v[i], mdu_rem > 0);
                chk("m_cnt", get_cnt(i), cnt[i]);
                if (branch) ld_rem_nx[i] = 0;
                else if (ld_rem[i] > 0) ld_rem_nx[i] = ld_rem[i] - 1;
                else if (lh) ld_rem_nx[i] = LAT[i] - 1;
                else ld_rem_nx[i] = 0;
                cnt_nx[i] = (e_ctrl && cnt[i] < CMAX[i]) ? cnt[i] + 1 : cnt[i];
            end
        end
        mdu_rem_nx = mdu_start ? 4 : (mdu_rem > 0 ? mdu_rem - 1 : 0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                ld_rem[i] = 0;
                cnt[i] = 0;
            end
            mdu_rem = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                ld_rem[i] = ld_rem_nx[i];
                cnt[i] = cnt_nx[i];
            end
            mdu_rem = mdu_rem_nx;
        end
    end

    task automatic clr();
        mem_read = 0; uses_rs = 0; uses_rt = 0; mdu_start = 0;
        uses_mdu = 0; branch = 0; ex_rt = 0; rs = 0; rt = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic load_hit(input logic [4:0] r);
        mem_read = 1; ex_rt = r; rs = r; uses_rs = 1;
    endtask

    initial begin
        clr();
        // LOAD_LAT=1 single bubble, and r0 destination never hazards
        do_reset();
        #1;
        chk("reset_pc", pc_v[0], 1);
        chk("reset_ctrl", ctrl_v[0], 0);
        chk("reset_cnt", sc0, 0);
        chk("reset_busy", busy_v[0], 0);
        cyc(); load_hit(5);
        #1 chk("t1_pc", pc_v[0], 0);
        chk("t1_ifid", ifid_v[0], 0);
        chk("t1_ctrl", ctrl_v[0], 1);
        cyc(); clr();
        #1 chk("t1_release", pc_v[0], 1);
        chk("t1_cnt", sc0, 1);
        cyc(); load_hit(0);
        #1 chk("t1_r0", ctrl_v[0], 0);

        // LOAD_LAT=3 on rt field
        do_reset();
        cyc(); clr(); mem_read = 1; ex_rt = 7; rt = 7; uses_rt = 1; rs = 3; uses_rs = 1;
        #1 chk("t2_c0", ctrl_v[1], 1);
        cyc(); clr();
        #1 chk("t2_c1", ctrl_v[1], 1);
        chk("t2_c1_pc", pc_v[1], 0);
        cyc();
        #1 chk("t2_c2", ctrl_v[1], 1);
        cyc();
        #1 chk("t2_c3_pc", pc_v[1], 1);
        chk("t2_cnt", sc1, 3);
        cyc(); mem_read = 1; ex_rt = 7; rt = 7; uses_rt = 0; rs = 3; uses_rs = 1;
        #1 chk("t2_no_use", ctrl_v[1], 0);

        // MDU interlock
        do_reset();
        cyc(); clr(); mdu_start = 1;
        #1 chk("t3_busy0", busy_v[0], 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(); mdu_start = 0; uses_mdu = 1;
            #1 chk("t3_stall", ctrl_v[0], 1);
            chk("t3_busy", busy_v[0], 1);
        end
        cyc();
        #1 chk("t3_rel", ctrl_v[0], 0);
        chk("t3_busy5", busy_v[0], 0);
        chk("t3_pc", pc_v[0], 1);

        // Branch during first LD_WAIT cycle
        do_reset();
        cyc(); load_hit(9);
        #1 chk("t4a_c0", ctrl_v[1], 1);
        cyc(); clr(); branch = 1;
        #1 chk("t4a_iff", iff_v[1], 1);
        chk("t4a_exf", exf_v[1], 1);
        chk("t4a_pc", pc_v[1], 1);
        chk("t4a_ctrl", ctrl_v[1], 0);
        cyc(); clr();
        #1 chk("t4a_after", ctrl_v[1], 0);
        chk("t4a_cnt", sc1, 1);

        // Branch during second LD_WAIT cycle
        do_reset();
        cyc(); load_hit(9);
        cyc(); clr();
        #1 chk("t4b_c1", ctrl_v[1], 1);
        cyc(); branch = 1;
        #1 chk("t4b_iff", iff_v[1], 1);
        chk("t4b_pc", pc_v[1], 1);
        chk("t4b_ctrl", ctrl_v[1], 0);
        cyc(); clr();
        #1 chk("t4b_after", ctrl_v[1], 0);
        chk("t4b_cnt", sc1, 2);

        // Load and MDU hazards together count once per cycle
        do_reset();
        cyc(); mdu_start = 1;
        cyc(); mdu_start = 0; load_hit(4); uses_mdu = 1;
        #1 chk("t5_ctrl", ctrl_v[0], 1);
        cyc();
        cyc(); clr();
        #1 chk("t5_cnt", sc0, 2);

        // Saturation of a 2-bit counter
        do_reset();
        cyc(); load_hit(6);
        repeat (4) cyc();
        cyc(); clr();
        #1 chk("t6_sat", sc2, 3);
        chk("t6_wide", sc0, 5);

        // Asynchronous reset in the middle of LD_WAIT
        do_reset();
        cyc(); load_hit(8); mdu_start = 1;
        cyc(); clr();
        #1 chk("t7_wait", ctrl_v[1], 1);
        #1 rst_n = 0;
        #1 chk("t7_pc", pc_v[1], 1);
        chk("t7_ifid", ifid_v[1], 1);
        chk("t7_ctrl", ctrl_v[1], 0);
        chk("t7_cnt", sc1, 0);
        chk("t7_busy", busy_v[1], 0);
        cyc(); cyc(); rst_n = 1;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
